// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor computing diff = din_one - din_two - bin,
// one bit per clock, LSB first, with a start/done handshake.
// Latency is WIDTH clocks from the accepting edge to the SHIFT->DONE edge.
// diff and bout change only at the SHIFT->DONE edge. They hold that value until the
// next result, so the in-flight result is never visible on the outputs.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the ovf output, which flags
// two's-complement signed overflow of the subtraction.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] din_one,
   input  logic [WIDTH-1:0] din_two,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
   output logic             bout,
   output logic             ovf
`else
   output logic             bout
`endif
);

   // The counter only has to reach WIDTH-1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;        // minuend, shifted right one bit per step
   logic [WIDTH-1:0] b_q, b_d;        // subtrahend, shifted right one bit per step
   logic [WIDTH-1:0] res_q, res_d;    // working result, filled from the MSB end
   logic             br_q, br_d;      // running borrow between bit positions
   logic [CW-1:0]    cnt_q, cnt_d;    // index of the bit being processed
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   // One full-subtractor slice acting on the current LSBs of the operand registers.
   logic a_bit, b_bit, d_bit, br_nx;
   assign a_bit = a_q[0];
   assign b_bit = b_q[0];
   assign d_bit = a_bit ^ b_bit ^ br_q;
   assign br_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

   // Next-state and datapath updates; every register holds its value by default.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = din_one;
               b_d     = din_two;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            res_d = {d_bit, res_q[WIDTH-1:1]};
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            br_d  = br_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // Publish the complete result in one step, never a partial one.
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = br_nx;
`ifdef SERIAL_SUB_OVERFLOW_EN
               // br_q is the borrow into the MSB stage here; signed overflow occurs
               // when it differs from the borrow out of that stage.
               ovf_d   = br_q ^ br_nx;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   // Overflow flag register. It updates on the same edge as diff and bout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor (WIDTH=8)
// against an integer-arithmetic reference model. Honors SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] din_one = '0;
   logic [W-1:0] din_two = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .din_one (din_one),
      .din_two (din_two),
      .bin     (bin),
      .busy    (busy),
      .done    (done),
      .diff    (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
      .bout    (bout),
      .ovf     (ovf)
`else
      .bout    (bout)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: exact integer subtraction, reduced modulo 2^W.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output logic [W-1:0] md, output logic mb, output logic mo);
      int r, sa, sb, sr;
      r  = int'(a) - int'(b) - int'(bi);
      md = r[W-1:0];
      mb = (r < 0);
      sa = int'(a) - (a[W-1] ? (1 << W) : 0);
      sb = int'(b) - (b[W-1] ? (1 << W) : 0);
      sr = sa - sb - int'(bi);
      mo = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
   endtask

   // Wait for IDLE, issue one request, and return #1 after the edge that raises done.
   // This task only measures; the calling tests make the comparisons.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output int edges, output bit stable, output bit busy_t0);
      logic [W-1:0] pd;
      logic         pb;
      @(negedge clk);
      while (busy) @(negedge clk);
      pd = diff;
      pb = bout;
      din_one = a;
      din_two = b;
      bin = bi;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy_t0 = busy;
      din_one = W'($urandom);
      din_two = W'($urandom);
      bin = 1'($urandom);
      edges = 0;
      stable = 1'b1;
      while (!done && edges < 4 * W) begin
         @(posedge clk);
         #1;
         edges++;
         if (!done && (diff !== pd || bout !== pb)) stable = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done);
      end
      checks++;
      if (diff !== '0 || bout !== 1'b0) begin
         errors++;
         $display("FAIL reset_data diff=%h bout=%b expected 00 0", diff, bout);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf ovf=%b expected 0", ovf);
      end
`endif
      rst_n = 1'b1;
      $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
   endtask

   task automatic test_directed;
      logic [W-1:0] va[3]  = '{8'h5A, 8'h00, 8'h10};
      logic [W-1:0] vb[3]  = '{8'h23, 8'h01, 8'h10};
      logic         vi[3]  = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] ed[3]  = '{8'h37, 8'hFF, 8'hFF};
      logic         eb[3]  = '{1'b0, 1'b1, 1'b1};
      int edges;
      bit stable, busy_t0;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], vi[i], edges, stable, busy_t0);
         $display("directed %h-%h-%b: diff=%h bout=%b edges=%0d", va[i], vb[i], vi[i], diff, bout, edges);
         checks++;
         if (busy_t0 !== 1'b1) begin
            errors++;
            $display("FAIL dir_busy_t0 busy=%b expected 1", busy_t0);
         end
         checks++;
         if (edges != W) begin
            errors++;
            $display("FAIL dir_latency edges=%0d expected %0d", edges, W);
         end
         checks++;
         if (diff !== ed[i] || bout !== eb[i]) begin
            errors++;
            $display("FAIL dir_result diff=%h bout=%b expected %h %b", diff, bout, ed[i], eb[i]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dir_done_pulse done=%b busy=%b expected 0 0", done, busy);
         end
      end
   endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
   task automatic test_overflow;
      logic [W-1:0] va[2] = '{8'h80, 8'h05};
      logic [W-1:0] vb[2] = '{8'h01, 8'h03};
      logic [W-1:0] ed[2] = '{8'h7F, 8'h02};
      logic         eo[2] = '{1'b1, 1'b0};
      int edges;
      bit stable, busy_t0;
      for (int i = 0; i < 2; i++) begin
         do_op(va[i], vb[i], 1'b0, edges, stable, busy_t0);
         $display("overflow %h-%h: diff=%h bout=%b ovf=%b", va[i], vb[i], diff, bout, ovf);
         checks++;
         if (diff !== ed[i] || bout !== 1'b0 || ovf !== eo[i]) begin
            errors++;
            $display("FAIL ovf_result diff=%h bout=%b ovf=%b expected %h 0 %b", diff, bout, ovf, ed[i], eo[i]);
         end
      end
   endtask
`endif

   task automatic test_ignore_start;
      int edges;
      @(negedge clk);
      while (busy) @(negedge clk);
      din_one = 8'h0F;
      din_two = 8'h01;
      bin = 1'b0;
      start = 1'b1;
      @(posedge clk);                 // T0
      #1;
      start = 1'b0;
      @(posedge clk);                 // T1
      @(posedge clk);                 // T2
      #1;
      din_one = 8'hFF;
      din_two = 8'hFF;
      start = 1'b1;
      @(posedge clk);                 // T3: request while busy
      #1;
      start = 1'b0;
      edges = 3;
      while (!done && edges < 4 * W) begin
         @(posedge clk);
         #1;
         edges++;
      end
      $display("ignore_start 0F-01: diff=%h bout=%b edges=%0d", diff, bout, edges);
      checks++;
      if (edges != W) begin
         errors++;
         $display("FAIL ign_latency edges=%0d expected %0d", edges, W);
      end
      checks++;
      if (diff !== 8'h0E || bout !== 1'b0) begin
         errors++;
         $display("FAIL ign_result diff=%h bout=%b expected 0e 0", diff, bout);
      end
   endtask

   // Called while the DONE cycle of the previous operation is visible.
   task automatic test_back_to_back;
      int edges;
      @(negedge clk);                 // still the DONE cycle
      @(negedge clk);                 // first IDLE cycle
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle busy=%b expected 0", busy);
      end
      din_one = 8'h33;
      din_two = 8'h11;
      bin = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept busy=%b expected 1", busy);
      end
      edges = 0;
      while (!done && edges < 4 * W) begin
         @(posedge clk);
         #1;
         edges++;
      end
      $display("back_to_back 33-11: diff=%h bout=%b edges=%0d", diff, bout, edges);
      checks++;
      if (edges != W || diff !== 8'h22 || bout !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result edges=%0d diff=%h bout=%b expected %0d 22 0", edges, diff, bout, W);
      end
   endtask

   task automatic test_reset_mid;
      bit saw_done;
      @(negedge clk);
      while (busy) @(negedge clk);
      din_one = 8'hAA;
      din_two = 8'h55;
      bin = 1'b0;
      start = 1'b1;
      @(posedge clk);                 // T0
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);      // T1..T3
      #1;
      rst_n = 1'b0;
      @(posedge clk);                 // T4 under reset
      #1;
      rst_n = 1'b1;
      $display("reset_mid: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset busy=%b done=%b diff=%h bout=%b expected 0 0 00 0", busy, done, diff, bout);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL mid_no_done activity=1 expected 0");
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a, b, md;
      logic         bi, mb, mo;
      int edges, bad;
      bit stable, busy_t0;
      for (int n = 0; n < 1000; n++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         bi = 1'($urandom);
         model(a, b, bi, md, mb, mo);
         do_op(a, b, bi, edges, stable, busy_t0);
         bad = 0;
         checks++;
         if (edges != W) begin
            errors++; bad++;
            $display("FAIL rnd_latency op=%0d edges=%0d expected %0d", n, edges, W);
         end
         checks++;
         if (!stable) begin
            errors++; bad++;
            $display("FAIL rnd_stable op=%0d diff/bout changed before done", n);
         end
         checks++;
         if (diff !== md || bout !== mb) begin
            errors++; bad++;
            $display("FAIL rnd_result op=%0d %h-%h-%b diff=%h bout=%b expected %h %b", n, a, b, bi, diff, bout, md, mb);
         end
`ifdef SERIAL_SUB_OVERFLOW_EN
         checks++;
         if (ovf !== mo) begin
            errors++; bad++;
            $display("FAIL rnd_ovf op=%0d %h-%h-%b ovf=%b expected %b", n, a, b, bi, ovf, mo);
         end
`endif
         $display("random %0d: %h-%h-%b diff=%h bout=%b ovf_ref=%b errs=%0d", n, a, b, bi, diff, bout, mo, bad);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
`ifdef SERIAL_SUB_OVERFLOW_EN
      test_overflow();
`endif
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
